fixed_divider: RTL and testbench

Sequential signed fixed-point divider, the inverse of the pipeline's combinational fixed-point multiplier. It computes q = a / b in the same Q-format conventions. It is used by the quantization and normalisation stages, which need division by step sizes and gains. It is an iterative restoring divider producing one quotient bit per cycle, with valid/ready handshakes on both sides, and accepts one operation at a time.

---
 rtl/fixed_divider.sv | 160 ++++++++++++++++
 tb/tb_fixed_divider.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_divider.sv
// Sequential signed fixed-point divider (restoring, one quotient bit per cycle).
// Optional round-half-away-from-zero when DIVIDER_ROUND_EN is defined.
module fixed_divider #(
  parameter int unsigned Width    = 16,
  parameter int unsigned InPoint  = 10,
  parameter int unsigned OutPoint = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] q_o,
  output logic             ovf_o,
  output logic             dz_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  // Input fraction bits cancel in the ratio; only OutPoint scales the dividend.
  localparam int unsigned Shift = OutPoint + InPoint - InPoint;
  localparam int unsigned N     = Width + Shift;
`ifdef DIVIDER_ROUND_EN
  localparam int unsigned Iter  = N + 1;
`else
  localparam int unsigned Iter  = N;
`endif
  localparam int unsigned CntW  = $clog2(Iter + 1);
  localparam logic [N:0]  MaxMag = (N+1)'((64'd1 << (Width-1)) - 64'd1);
  localparam logic [N:0]  MinMag = (N+1)'(64'd1 << (Width-1));

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_e;

  state_e            state, state_n;
  logic [N-1:0]      dvd;
  logic [Width-1:0]  dvs;
  logic [Width-1:0]  rem;
  logic [Iter-1:0]   quo;
  logic [CntW-1:0]   cnt;
  logic              sign;
  logic              dz;
  logic              aneg;

  logic [Width-1:0]  abs_a, abs_b;
  logic [Width:0]    rem_sh, trial;
  logic              ge;
  logic [N:0]        mag;
  logic [Width-1:0]  fix_q;
  logic              fix_ovf;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid_i) state_n = DIV;
      DIV:  if (cnt == CntW'(1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (out_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand magnitudes; the most negative value maps to 2^(Width-1) unsigned
  always_comb begin
    abs_a = a_i[Width-1] ? Width'(0) - a_i : a_i;
    abs_b = b_i[Width-1] ? Width'(0) - b_i : b_i;
  end

  // One restoring trial subtraction
  always_comb begin
    rem_sh = {rem, dvd[N-1]};
    trial  = rem_sh - {1'b0, dvs};
    ge     = ~trial[Width];
  end

  // Sign application and saturation of the final magnitude
  always_comb begin
    fix_q   = '0;
    fix_ovf = 1'b0;
`ifdef DIVIDER_ROUND_EN
    mag = (N+1)'(quo[Iter-1:1]) + (N+1)'(quo[0]);
`else
    mag = (N+1)'(quo);
`endif
    if (dz) begin
      fix_q = aneg ? MinMag[Width-1:0] : MaxMag[Width-1:0];
    end else if (sign) begin
      if (mag > MinMag) begin
        fix_q   = MinMag[Width-1:0];
        fix_ovf = 1'b1;
      end else begin
        fix_q = Width'(0) - mag[Width-1:0];
      end
    end else if (mag > MaxMag) begin
      fix_q   = MaxMag[Width-1:0];
      fix_ovf = 1'b1;
    end else begin
      fix_q = mag[Width-1:0];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      dz          <= 1'b0;
      aneg        <= 1'b0;
      in_ready_o  <= 1'b1;
      q_o         <= '0;
      ovf_o       <= 1'b0;
      dz_o        <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      in_ready_o <= (state_n == IDLE);
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            dvd  <= N'(abs_a) << Shift;
            dvs  <= abs_b;
            rem  <= '0;
            quo  <= '0;
            cnt  <= CntW'(Iter);
            sign <= a_i[Width-1] ^ b_i[Width-1];
            dz   <= (b_i == '0);
            aneg <= a_i[Width-1];
          end
        end
        DIV: begin
          rem <= ge ? trial[Width-1:0] : rem_sh[Width-1:0];
          dvd <= dvd << 1;
          quo <= {quo[Iter-2:0], ge};
          cnt <= cnt - CntW'(1);
        end
        FIX: begin
          q_o         <= fix_q;
          ovf_o       <= fix_ovf;
          dz_o        <= dz;
          out_valid_o <= 1'b1;
        end
        DONE: begin
          if (out_ready_i) out_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider.sv
// Scoreboard bench for fixed_divider: arithmetic reference model, directed and random ops.
`timescale 1ns/1ps
module tb_fixed_divider;

  localparam int W  = 16;
  localparam int OP = 10;
`ifdef DIVIDER_ROUND_EN
  localparam int LAT = W + OP + 2;
`else
  localparam int LAT = W + OP + 1;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  q_o;
  logic          ovf_o;
  logic          dz_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;

  fixed_divider dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .q_o         (q_o),
    .ovf_o       (ovf_o),
    .dz_o        (dz_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int q;
    int ovf;
    int dz;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   rdy_rand = 1'b0;

  task automatic check(input string nm, input int act, input int req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: exact rational arithmetic, then round/truncate and clamp
  function automatic exp_t model(input int a, input int b);
    exp_t   e;
    longint num, mag, res, an, bn;
    e.dz = 0; e.ovf = 0;
    if (b == 0) begin
      e.dz = 1;
      e.q  = (a < 0) ? -32768 : 32767;
      return e;
    end
    num = longint'(a) * (longint'(1) << OP);
`ifdef DIVIDER_ROUND_EN
    an  = (num < 0) ? -num : num;
    bn  = (b < 0) ? -longint'(b) : longint'(b);
    mag = (an * 2 / bn + 1) / 2;
    res = ((a < 0) != (b < 0)) ? -mag : mag;
`else
    an = 0; bn = 0; mag = 0;
    res = num / longint'(b);
`endif
    if (res > 32767) begin
      res = 32767; e.ovf = 1;
    end else if (res < -32768) begin
      res = -32768; e.ovf = 1;
    end
    e.q = int'(res);
    return e;
  endfunction

  task automatic issue(input int a, input int b);
    int n = 0;
    while (!in_ready_o && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    if (!in_ready_o) check("issue_timeout", 0, 1);
    a_i = W'(a); b_i = W'(b); in_valid_i = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && n < 400) begin
      @(posedge clk_i); #1; n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Random consumer backpressure when enabled
  always @(posedge clk_i) begin
    #1;
    if (rdy_rand) out_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency tracking and scoreboard pops on each consumed result
  int negcnt  = 0;
  int acc_neg = 0;
  bit vprev   = 1'b0;
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (in_valid_i && in_ready_o) acc_neg = negcnt;
      if (out_valid_o && !vprev) check("latency", negcnt - acc_neg - 1, LAT);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("q",   int'($signed(q_o)), e.q);
          check("ovf", int'(ovf_o), e.ovf);
          check("dz",  int'(dz_o), e.dz);
        end
      end
    end
    vprev = out_valid_o;
    negcnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a, b, r;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_in_ready", int'(in_ready_o), 1);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_q", int'(q_o), 0);
    check("rst_ovf", int'(ovf_o), 0);
    check("rst_dz", int'(dz_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed cases
    issue(3072, 2048);
    issue(2048, 3072);
    issue(-2048, 3072);
    issue(31744, 512);
    issue(-32768, 1024);
    issue(-5120, 0);
    issue(0, 0);
    issue(-32768, -1024);
    issue(1, 32767);
    issue(-1, 3);
    drain();

    // Backpressure: result held, new operands ignored
    out_ready_i = 1'b0;
    issue(3072, 2048);
    n = 0;
    while (!out_valid_o && n < 60) begin
      @(posedge clk_i); #1; n++;
    end
    check("bp_valid_seen", int'(out_valid_o), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_q_stable", int'($signed(q_o)), 1536);
      check("bp_in_ready", int'(in_ready_o), 0);
      check("bp_out_valid", int'(out_valid_o), 1);
      a_i = 16'd100; b_i = 16'd7; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_release_in_ready", int'(in_ready_o), 1);
    check("bp_release_out_valid", int'(out_valid_o), 0);
    repeat (40) @(posedge clk_i);
    #1;
    check("bp_ignored_no_result", int'(out_valid_o), 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset during DIV discards the operation
    issue(2048, 3072);
    repeat (9) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i); #1;
    check("abort_out_valid", int'(out_valid_o), 0);
    check("abort_q", int'(q_o), 0);
    check("abort_in_ready", int'(in_ready_o), 1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    issue(-3072, 2048);
    drain();

    // Randomized operations with random consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      a = int'($signed(W'($urandom)));
      if (r == 7) a = -32768;
      case (r)
        0:       b = 0;
        1:       b = $urandom_range(1, 255);
        2:       b = -int'($urandom_range(1, 255));
        default: b = int'($signed(W'($urandom)));
      endcase
      issue(a, b);
    end
    drain();
    rdy_rand = 1'b0;
    out_ready_i = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
